// File: rtl/reduceron_run_monitor_if.sv
// Trace readout port of the Reduceron run monitor: a valid/ready stream of
// cycle-stamped IO writes.
interface reduceron_run_monitor_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 13,
  parameter int CNT_W  = 32
);
  logic              trace_valid;
  logic              trace_ready;
  logic [CNT_W-1:0]  trace_cycle;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;

  modport master (
    output trace_valid, trace_cycle, trace_addr, trace_data,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_cycle, trace_addr, trace_data,
    output trace_ready
  );
endinterface

// File: rtl/reduceron_run_monitor.sv
// Run monitor for a Reduceron core: cycle-stamped IO-write trace FIFO,
// saturating run statistics and a result latch captured on finish.
module reduceron_run_monitor #(
  parameter int RES_W      = 16,
  parameter int TAG_W      = 3,
  parameter int STATE_W    = 7,
  parameter int GC_BIT     = 5,
  parameter int HEAP_W     = 13,
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 13,
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W      = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [RES_W-1:0]         r,
  input  logic [STATE_W-1:0]       s,
  input  logic [HEAP_W-1:0]        h,
  input  logic                     iowrite,
  input  logic [ADDR_W-1:0]        ioaddr,
  input  logic [DATA_W-1:0]        iowd,
  input  logic                     finish,
  reduceron_run_monitor_if.master  trace,
  output logic [CNT_W-1:0]         trace_dropped,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         gc_count,
  output logic [CNT_W-1:0]         gc_cycles,
  output logic [HEAP_W-1:0]        heap_max,
  output logic                     done,
  output logic [RES_W-TAG_W-1:0]   result_value,
  output logic [TAG_W-1:0]         result_tag,
  output logic [CNT_W-1:0]         done_cycle
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int ENT_W = CNT_W + ADDR_W + DATA_W;
  localparam int PTR_W = DEPTH_LOG2 + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic                   done_q, done_d;
  logic                   gc_q, gc_d;
  logic [CNT_W-1:0]       cycle_q, cycle_d;
  logic [CNT_W-1:0]       gc_cnt_q, gc_cnt_d;
  logic [CNT_W-1:0]       gc_cyc_q, gc_cyc_d;
  logic [CNT_W-1:0]       dropped_q, dropped_d;
  logic [CNT_W-1:0]       done_cycle_q, done_cycle_d;
  logic [HEAP_W-1:0]      heap_max_q, heap_max_d;
  logic [RES_W-TAG_W-1:0] res_val_q, res_val_d;
  logic [TAG_W-1:0]       res_tag_q, res_tag_d;

  logic running, push, pop, full, empty, wr_en, drop;
  logic [ENT_W-1:0] head;

  assign running = !done_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign push    = running && iowrite;
  assign pop     = !empty && trace.trace_ready;
  // When full, a simultaneous pop frees the very slot the push writes into.
  assign wr_en   = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign head              = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign trace.trace_valid = !empty;
  assign trace.trace_cycle = empty ? '0 : head[ENT_W-1 -: CNT_W];
  assign trace.trace_addr  = empty ? '0 : head[DATA_W +: ADDR_W];
  assign trace.trace_data  = empty ? '0 : head[DATA_W-1:0];

  always_comb begin
    wr_ptr_d     = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    dropped_d    = drop  ? sat_inc(dropped_q) : dropped_q;
    gc_d         = s[GC_BIT];
    done_d       = done_q;
    cycle_d      = cycle_q;
    gc_cnt_d     = gc_cnt_q;
    gc_cyc_d     = gc_cyc_q;
    heap_max_d   = heap_max_q;
    done_cycle_d = done_cycle_q;
    res_val_d    = res_val_q;
    res_tag_d    = res_tag_q;
    if (running) begin
      cycle_d = sat_inc(cycle_q);
      if (s[GC_BIT] && !gc_q) gc_cnt_d = sat_inc(gc_cnt_q);
      if (s[GC_BIT])          gc_cyc_d = sat_inc(gc_cyc_q);
      if (h > heap_max_q)     heap_max_d = h;
      if (finish) begin
        done_d       = 1'b1;
        done_cycle_d = cycle_q;
        res_val_d    = r[RES_W-1:TAG_W];
        res_tag_d    = r[TAG_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      dropped_q    <= '0;
      gc_q         <= 1'b0;
      done_q       <= 1'b0;
      cycle_q      <= '0;
      gc_cnt_q     <= '0;
      gc_cyc_q     <= '0;
      heap_max_q   <= '0;
      done_cycle_q <= '0;
      res_val_q    <= '0;
      res_tag_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dropped_q    <= dropped_d;
      gc_q         <= gc_d;
      done_q       <= done_d;
      cycle_q      <= cycle_d;
      gc_cnt_q     <= gc_cnt_d;
      gc_cyc_q     <= gc_cyc_d;
      heap_max_q   <= heap_max_d;
      done_cycle_q <= done_cycle_d;
      res_val_q    <= res_val_d;
      res_tag_q    <= res_tag_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {cycle_q, ioaddr, iowd};
  end

  assign trace_dropped = dropped_q;
  assign cycle_count   = cycle_q;
  assign gc_count      = gc_cnt_q;
  assign gc_cycles     = gc_cyc_q;
  assign heap_max      = heap_max_q;
  assign done          = done_q;
  assign result_value  = res_val_q;
  assign result_tag    = res_tag_q;
  assign done_cycle    = done_cycle_q;

endmodule

// File: tb/tb_reduceron_run_monitor.sv
// Directed bench for reduceron_run_monitor: expected trace entries are queued
// at stimulus time and compared by a separate monitor on each accepted beat.
module tb_reduceron_run_monitor;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] r;
  logic [6:0]  s;
  logic [12:0] h;
  logic        iowrite;
  logic [12:0] ioaddr;
  logic [12:0] iowd;
  logic        finish;
  logic [31:0] trace_dropped, cycle_count, gc_count, gc_cycles, done_cycle;
  logic [12:0] heap_max;
  logic        done;
  logic [12:0] result_value;
  logic [2:0]  result_tag;

  int errors = 0;
  int checks = 0;
  logic [57:0] exp_q[$];

  reduceron_run_monitor_if #(.ADDR_W(13), .DATA_W(13), .CNT_W(32)) tr_if ();

  reduceron_run_monitor dut (
    .clock(clock), .reset(reset), .r(r), .s(s), .h(h),
    .iowrite(iowrite), .ioaddr(ioaddr), .iowd(iowd), .finish(finish),
    .trace(tr_if),
    .trace_dropped(trace_dropped), .cycle_count(cycle_count),
    .gc_count(gc_count), .gc_cycles(gc_cycles), .heap_max(heap_max),
    .done(done), .result_value(result_value), .result_tag(result_tag),
    .done_cycle(done_cycle)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every beat the DUT offers and the consumer accepts.
  always @(negedge clock) begin
    if (!reset && tr_if.trace_valid && tr_if.trace_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL trace_unexpected: got 0x%0h expected no entry",
                 {tr_if.trace_cycle, tr_if.trace_addr, tr_if.trace_data});
      end else begin
        logic [57:0] e;
        e = exp_q.pop_front();
        if ({tr_if.trace_cycle, tr_if.trace_addr, tr_if.trace_data} !== e) begin
          errors++;
          $display("FAIL trace_entry: got 0x%0h expected 0x%0h",
                   {tr_if.trace_cycle, tr_if.trace_addr, tr_if.trace_data}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    r = '0; s = '0; h = '0; iowrite = 1'b0; ioaddr = '0; iowd = '0; finish = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},    {63'd0, tr_if.trace_valid}, 64'd0);
    check({tag, "_tcycle"},   {32'd0, tr_if.trace_cycle}, 64'd0);
    check({tag, "_dropped"},  {32'd0, trace_dropped}, 64'd0);
    check({tag, "_cycles"},   {32'd0, cycle_count}, 64'd0);
    check({tag, "_gc"},       {32'd0, gc_count}, 64'd0);
    check({tag, "_gccyc"},    {32'd0, gc_cycles}, 64'd0);
    check({tag, "_heap"},     {51'd0, heap_max}, 64'd0);
    check({tag, "_done"},     {63'd0, done}, 64'd0);
    check({tag, "_result"},   {48'd0, result_value, result_tag}, 64'd0);
    check({tag, "_donecyc"},  {32'd0, done_cycle}, 64'd0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tr_if.trace_ready = 1'b0;
    do_reset();
    check_zero("rst");

    // 10 idle running cycles
    for (int c = 0; c < 10; c++) tick();
    check("idle_cycles", {32'd0, cycle_count}, 64'd10);
    check("idle_gc", {32'd0, gc_count}, 64'd0);
    check("idle_heap", {51'd0, heap_max}, 64'd0);
    check("idle_valid", {63'd0, tr_if.trace_valid}, 64'd0);
    check("idle_done", {63'd0, done}, 64'd0);

    // Two writes, consumer becomes ready at cycle 10
    do_reset();
    for (int c = 0; c < 16; c++) begin
      idle();
      tr_if.trace_ready = (c >= 10);
      if (c == 3) begin
        iowrite = 1'b1; ioaddr = 13'd5; iowd = 13'd100;
        exp_q.push_back({32'd3, 13'd5, 13'd100});
      end
      if (c == 7) begin
        iowrite = 1'b1; ioaddr = 13'd6; iowd = 13'd200;
        exp_q.push_back({32'd7, 13'd6, 13'd200});
      end
      tick();
      if (c == 8) begin
        check("stall_cycle", {32'd0, tr_if.trace_cycle}, 64'd3);
        check("stall_addr", {51'd0, tr_if.trace_addr}, 64'd5);
        check("stall_data", {51'd0, tr_if.trace_data}, 64'd100);
      end
    end
    check("two_drained", {63'd0, tr_if.trace_valid}, 64'd0);
    check("two_queue", 64'(exp_q.size()), 64'd0);

    // Overflow: 20 writes into a 16-deep FIFO with no consumer
    tr_if.trace_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      idle();
      iowrite = 1'b1; ioaddr = 13'(c); iowd = 13'(c + 1);
      if (c < 16) exp_q.push_back({32'(c), 13'(c), 13'(c + 1)});
      tick();
    end
    idle();
    check("ovf_dropped", {32'd0, trace_dropped}, 64'd4);
    check("ovf_valid", {63'd0, tr_if.trace_valid}, 64'd1);
    iowrite = 1'b1; ioaddr = 13'd20; iowd = 13'd21;
    tr_if.trace_ready = 1'b1;
    exp_q.push_back({32'd20, 13'd20, 13'd21});
    tick();
    idle();
    tr_if.trace_ready = 1'b0;
    check("full_pushpop_dropped", {32'd0, trace_dropped}, 64'd4);
    tr_if.trace_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    check("ovf_drained", {63'd0, tr_if.trace_valid}, 64'd0);
    check("ovf_queue", 64'(exp_q.size()), 64'd0);
    check("ovf_cycles", {32'd0, cycle_count}, 64'd41);

    // GC episodes, heap peak, finish with simultaneous iowrite
    do_reset();
    tr_if.trace_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      idle();
      s[5] = ((c >= 2 && c <= 4) || (c == 8) || (c == 9));
      case (c)
        1: h = 13'd10;
        2: h = 13'd300;
        3: h = 13'd40;
        default: h = 13'd0;
      endcase
      if (c == 12) begin
        finish = 1'b1; r = 16'h002B;
        iowrite = 1'b1; ioaddr = 13'd9; iowd = 13'd77;
        exp_q.push_back({32'd12, 13'd9, 13'd77});
      end
      tick();
    end
    idle();
    check("fin_done", {63'd0, done}, 64'd1);
    check("fin_value", {51'd0, result_value}, 64'd5);
    check("fin_tag", {61'd0, result_tag}, 64'd3);
    check("fin_donecyc", {32'd0, done_cycle}, 64'd12);
    check("fin_cycles", {32'd0, cycle_count}, 64'd13);
    check("gc_count", {32'd0, gc_count}, 64'd2);
    check("gc_cycles", {32'd0, gc_cycles}, 64'd5);
    check("heap_max", {51'd0, heap_max}, 64'd300);
    tick();
    // Post-done activity must be ignored
    for (int c = 0; c < 6; c++) begin
      finish = 1'b1; r = 16'h0000;
      iowrite = 1'b1; ioaddr = 13'd1; iowd = 13'd2;
      s[5] = c[0]; h = 13'd1000;
      tick();
    end
    idle();
    tick();
    check("frz_value", {51'd0, result_value}, 64'd5);
    check("frz_tag", {61'd0, result_tag}, 64'd3);
    check("frz_donecyc", {32'd0, done_cycle}, 64'd12);
    check("frz_cycles", {32'd0, cycle_count}, 64'd13);
    check("frz_gc", {32'd0, gc_count}, 64'd2);
    check("frz_gccyc", {32'd0, gc_cycles}, 64'd5);
    check("frz_heap", {51'd0, heap_max}, 64'd300);
    check("frz_valid", {63'd0, tr_if.trace_valid}, 64'd0);
    check("frz_queue", 64'(exp_q.size()), 64'd0);

    // Mid-run reset with three queued entries, then a fresh finish
    tr_if.trace_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle();
      iowrite = 1'b1; ioaddr = 13'(c + 2); iowd = 13'(c + 3); h = 13'd50;
      tick();
    end
    idle();
    tick();
    check("pre_rst_valid", {63'd0, tr_if.trace_valid}, 64'd1);
    reset = 1'b1;
    tick();
    check_zero("midrst");
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 4) begin
        finish = 1'b1; r = 16'h00F1;
      end
      tick();
    end
    idle();
    check("refin_done", {63'd0, done}, 64'd1);
    check("refin_value", {51'd0, result_value}, 64'd30);
    check("refin_tag", {61'd0, result_tag}, 64'd1);
    check("refin_donecyc", {32'd0, done_cycle}, 64'd4);
    check("refin_valid", {63'd0, tr_if.trace_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
